// File: rtl/fifo_burst_scheduler.sv
// Burst scheduler for the capture-path prefetch FIFO: counts fill, issues full or flush-remainder DDR write bursts.
// burst_req rises 2 cycles after the enabling write; beats pass combinationally and stall on out_ready/fifo_rd_vld.
module fifo_burst_scheduler #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    DEPTH_WIDTH = 11,
  parameter int                    BURST_LEN   = 64,
  parameter int                    ADDR_WIDTH  = 28,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   fifo_wr_en,
  output logic [DATA_WIDTH-1:0]  fifo_wr_data,
  input  logic                   fifo_wr_vld,
  output logic                   fifo_rd_en,
  input  logic                   fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   frame_start,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   burst_req,
  input  logic                   burst_ack,
  output logic [ADDR_WIDTH-1:0]  burst_addr,
  output logic [DEPTH_WIDTH:0]   burst_len,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [DEPTH_WIDTH:0]   level,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam logic [DEPTH_WIDTH:0] FULL_LEN = (DEPTH_WIDTH+1)'(BURST_LEN);
  localparam logic [DEPTH_WIDTH:0] ONE      = (DEPTH_WIDTH+1)'(1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DEPTH_WIDTH:0]    beat;
  logic                    flush_pend;
  logic                    frame_pend;
  logic                    partial;
  logic                    wr_evt;
  logic                    rd_evt;
  logic                    in_xfer;
  logic                    last_beat;

  // The upstream stream cannot stall; the FIFO write strobe simply mirrors it.
  assign in_ready     = fifo_wr_vld;
  assign fifo_wr_en   = in_valid;
  assign fifo_wr_data = in_data;

  assign wr_evt = fifo_wr_en & fifo_wr_vld;
  assign rd_evt = fifo_rd_en & fifo_rd_vld;

  assign in_xfer    = (state == XFER);
  assign out_valid  = in_xfer & fifo_rd_vld;
  assign out_data   = fifo_rd_data;
  assign fifo_rd_en = in_xfer & out_ready & fifo_rd_vld;
  assign out_last   = out_valid & (beat == (burst_len - ONE));
  assign last_beat  = out_last & out_ready;
  assign burst_addr = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_evt && !rd_evt) begin
        level <= level + ONE;
      end else if (rd_evt && !wr_evt) begin
        level <= level - ONE;
      end
      if (frame_start) begin
        overflow <= 1'b0;
      end else if (in_valid && !fifo_wr_vld) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= BASE_ADDR;
      burst_len  <= '0;
      burst_req  <= 1'b0;
      beat       <= '0;
      flush_pend <= 1'b0;
      frame_pend <= 1'b0;
      partial    <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (flush) begin
        flush_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (frame_start) begin
            addr <= BASE_ADDR;
          end
          // A fresh flush arriving while the old one is retired stays pending.
          if (level >= FULL_LEN) begin
            burst_len <= FULL_LEN;
            partial   <= 1'b0;
            burst_req <= 1'b1;
            state     <= REQ;
          end else if (flush_pend && (level != '0)) begin
            burst_len  <= level;
            partial    <= 1'b1;
            flush_pend <= flush;
            burst_req  <= 1'b1;
            state      <= REQ;
          end else if (flush_pend) begin
            flush_pend <= flush;
            flush_done <= 1'b1;
          end
        end
        REQ: begin
          if (frame_start) begin
            frame_pend <= 1'b1;
          end
          if (burst_ack) begin
            burst_req <= 1'b0;
            beat      <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (frame_start) begin
            frame_pend <= 1'b1;
          end
          if (rd_evt) begin
            beat <= beat + ONE;
          end
          // Frame restart overrides the post-burst address advance.
          if (last_beat) begin
            addr       <= (frame_pend || frame_start) ? BASE_ADDR
                                                      : addr + ADDR_WIDTH'(burst_len);
            frame_pend <= 1'b0;
            flush_done <= partial;
            partial    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// Directed bench: behavioural show-ahead FIFO, background word source, per-burst scoreboard.
`timescale 1ns/1ps
module tb_fifo_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        fifo_wr_vld;
  logic        fifo_rd_en;
  logic        fifo_rd_vld;
  logic [15:0] fifo_rd_data;
  logic        frame_start = 1'b0;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        burst_req;
  logic        burst_ack = 1'b0;
  logic [27:0] burst_addr;
  logic [11:0] burst_len;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic [11:0] level;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_goal = 0;
  int wr_seq = 0;
  int rd_seq = 0;

  fifo_burst_scheduler dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_vld(fifo_wr_vld),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
    .frame_start(frame_start), .flush(flush), .flush_done(flush_done),
    .burst_req(burst_req), .burst_ack(burst_ack), .burst_addr(burst_addr), .burst_len(burst_len),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model, 2048 x 16.
  logic [15:0] mem [0:2047];
  logic [10:0] wp, rp;
  logic [11:0] cnt;
  assign fifo_wr_vld  = (cnt < 12'd2048);
  assign fifo_rd_vld  = (cnt != 12'd0);
  assign fifo_rd_data = mem[rp];

  always @(posedge clk) begin
    if (fifo_wr_en && fifo_wr_vld) mem[wp] <= fifo_wr_data;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0; rp <= '0; cnt <= '0;
    end else begin
      if (fifo_wr_en && fifo_wr_vld) wp <= wp + 11'd1;
      if (fifo_rd_en && fifo_rd_vld) rp <= rp + 11'd1;
      cnt <= cnt + 12'(fifo_wr_en && fifo_wr_vld) - 12'(fifo_rd_en && fifo_rd_vld);
    end
  end

  // Word source: presents sequence numbers one per cycle until wr_goal is reached.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      wr_seq   = 0;
      in_valid = 1'b0;
    end else if (wr_seq < wr_goal) begin
      in_valid = 1'b1;
      in_data  = wr_seq[15:0];
      wr_seq++;
    end else begin
      in_valid = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_goal = 0;
    burst_ack = 1'b0; flush = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rd_seq = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_writes();
    int t = 0;
    while ((wr_seq < wr_goal || in_valid) && t < 4000) begin
      @(negedge clk); t++;
    end
    check_eq("writes_done", 64'(t < 4000), 64'd1);
  endtask

  // Wait for a request, hold it ack_dly cycles, then accept every beat of the burst.
  task automatic run_burst(input logic [27:0] exp_addr, input int exp_len, input int ack_dly,
                           input bit rnd_rdy, input bit lvl_const, input int fs_beat, input bit exp_fd);
    int t = 0;
    int beat = 0;
    int last_at = -1;
    int last_cnt = 0;
    int bad_data = 0;
    int moved = 0;
    int lvl_bad = 0;
    logic [11:0] lvl_ref;
    while (burst_req !== 1'b1 && t < 400) begin
      @(negedge clk); t++;
    end
    check_eq("req_seen", 64'(burst_req), 64'd1);
    check_eq("req_addr", 64'(burst_addr), 64'(exp_addr));
    check_eq("req_len", 64'(burst_len), 64'(exp_len));
    repeat (ack_dly) begin
      @(negedge clk);
      if (burst_req !== 1'b1 || burst_addr !== exp_addr || burst_len !== 12'(exp_len)) moved++;
    end
    check_eq("req_hold", 64'(moved), 64'd0);
    burst_ack = 1'b1;
    @(negedge clk);
    burst_ack = 1'b0;
    check_eq("req_drop", 64'(burst_req), 64'd0);
    lvl_ref = level;
    t = 0;
    while (beat < exp_len && t < 2000) begin
      out_ready   = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      frame_start = (beat == fs_beat);
      #1;
      if (lvl_const && level !== lvl_ref) lvl_bad++;
      if (out_valid && out_ready) begin
        if (out_data !== rd_seq[15:0]) bad_data++;
        rd_seq++;
        if (out_last) begin
          last_cnt++;
          last_at = beat;
        end
        beat++;
      end
      @(negedge clk); t++;
    end
    frame_start = 1'b0;
    out_ready   = 1'b1;
    check_eq("beats", 64'(beat), 64'(exp_len));
    check_eq("beat_data_err", 64'(bad_data), 64'd0);
    check_eq("last_pos", 64'(last_at), 64'(exp_len - 1));
    check_eq("last_cnt", 64'(last_cnt), 64'd1);
    if (lvl_const) check_eq("level_const", 64'(lvl_bad), 64'd0);
    check_eq("flush_done_end", 64'(flush_done), 64'(exp_fd));
    check_eq("post_valid", 64'(out_valid), 64'd0);
    check_eq("req_gap", 64'(burst_req), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values, sampled while reset is held.
    @(negedge clk);
    check_eq("rst_req", 64'(burst_req), 64'd0);
    check_eq("rst_addr", 64'(burst_addr), 64'd0);
    check_eq("rst_len", 64'(burst_len), 64'd0);
    check_eq("rst_level", 64'(level), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);
    check_eq("rst_fd", 64'(flush_done), 64'd0);
    check_eq("rst_oval", 64'(out_valid), 64'd0);
    check_eq("rst_olast", 64'(out_last), 64'd0);
    check_eq("rst_rden", 64'(fifo_rd_en), 64'd0);
    do_reset();

    // One full burst; request lands exactly two cycles after the 64th write.
    wr_goal = 64;
    repeat (65) @(negedge clk);
    check_eq("t1_level64", 64'(level), 64'd64);
    check_eq("t1_req_early", 64'(burst_req), 64'd0);
    @(negedge clk);
    check_eq("t1_req_on", 64'(burst_req), 64'd1);
    run_burst(28'd0, 64, 3, 1'b0, 1'b0, -1, 1'b0);
    check_eq("t1_level0", 64'(level), 64'd0);

    // frame_start in IDLE rewinds the address at once.
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check_eq("t2_fs_idle_addr", 64'(burst_addr), 64'd0);

    // 200 words: three full bursts, 8 left, flush drains them.
    wr_goal = wr_goal + 200;
    run_burst(28'd0, 64, 1, 1'b0, 1'b0, -1, 1'b0);
    run_burst(28'd64, 64, 1, 1'b0, 1'b0, -1, 1'b0);
    run_burst(28'd128, 64, 1, 1'b0, 1'b0, -1, 1'b0);
    wait_writes();
    repeat (3) @(negedge clk);
    check_eq("t2_level8", 64'(level), 64'd8);
    check_eq("t2_no_req", 64'(burst_req), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    run_burst(28'd192, 8, 2, 1'b0, 1'b0, -1, 1'b1);
    @(negedge clk);
    check_eq("t2_fd_pulse", 64'(flush_done), 64'd0);
    check_eq("t2_level_end", 64'(level), 64'd0);

    // Flush on an empty FIFO completes without a burst.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    check_eq("t3_fd", 64'(flush_done), 64'd1);
    check_eq("t3_noreq", 64'(burst_req), 64'd0);
    @(negedge clk);
    check_eq("t3_fd_off", 64'(flush_done), 64'd0);
    check_eq("t3_noreq2", 64'(burst_req), 64'd0);

    // Overflow: writer stalled, FIFO fills, extra words drop.
    do_reset();
    out_ready = 1'b0;
    wr_goal = 2050;
    wait_writes();
    repeat (2) @(negedge clk);
    check_eq("t4_level_full", 64'(level), 64'd2048);
    check_eq("t4_ovf", 64'(overflow), 64'd1);
    check_eq("t4_in_ready", 64'(in_ready), 64'd0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check_eq("t4_ovf_clr", 64'(overflow), 64'd0);
    wr_goal = wr_goal + 3;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check_eq("t4_clr_wins", 64'(overflow), 64'd0);
    @(negedge clk);
    check_eq("t4_ovf_reset", 64'(overflow), 64'd1);
    check_eq("t4_level_hold", 64'(level), 64'd2048);

    // Random out_ready and ack gaps, then a sustained read+write stream.
    do_reset();
    wr_goal = 64;
    run_burst(28'd0, 64, 4, 1'b1, 1'b0, -1, 1'b0);
    wr_goal = wr_goal + 300;
    run_burst(28'd64, 64, 1, 1'b0, 1'b1, -1, 1'b0);
    run_burst(28'd128, 64, 1, 1'b0, 1'b1, -1, 1'b0);
    run_burst(28'd192, 64, 2, 1'b1, 1'b0, -1, 1'b0);
    run_burst(28'd256, 64, 1, 1'b0, 1'b0, -1, 1'b0);
    wait_writes();
    check_eq("t5_level44", 64'(level), 64'd44);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    run_burst(28'd320, 44, 0, 1'b1, 1'b0, -1, 1'b1);

    // frame_start mid-burst at addr 64 takes effect when that burst ends.
    do_reset();
    wr_goal = 128;
    run_burst(28'd0, 64, 1, 1'b0, 1'b0, -1, 1'b0);
    run_burst(28'd64, 64, 1, 1'b0, 1'b0, 10, 1'b0);
    check_eq("t6_fs_addr", 64'(burst_addr), 64'd0);
    wr_goal = wr_goal + 64;
    run_burst(28'd0, 64, 1, 1'b0, 1'b0, -1, 1'b0);

    // Reset in the middle of a transfer.
    wr_goal = wr_goal + 64;
    begin
      int t = 0;
      while (burst_req !== 1'b1 && t < 400) begin
        @(negedge clk); t++;
      end
      check_eq("t6_req2", 64'(burst_req), 64'd1);
    end
    burst_ack = 1'b1;
    @(negedge clk);
    burst_ack = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("t6_mid_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_req", 64'(burst_req), 64'd0);
    check_eq("t6_rst_oval", 64'(out_valid), 64'd0);
    check_eq("t6_rst_olast", 64'(out_last), 64'd0);
    check_eq("t6_rst_rden", 64'(fifo_rd_en), 64'd0);
    check_eq("t6_rst_level", 64'(level), 64'd0);
    check_eq("t6_rst_addr", 64'(burst_addr), 64'd0);
    check_eq("t6_rst_len", 64'(burst_len), 64'd0);
    @(negedge clk);
    check_eq("t6_rst_hold", 64'(out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_scheduler.md
# fifo_burst_scheduler

Burst read scheduler for the 16-bit, 2048-deep single-clock prefetch FIFO on the video capture path. Accepts a non-stallable pixel stream into the FIFO, tracks fill level, and when a full burst (or a flush remainder) is available, requests a DDR write burst and drains exactly that many words to the memory writer. Generates incrementing burst addresses per frame and reports overflow.

## Interface
- DATA_WIDTH, 16, FIFO/stream word width
- DEPTH_WIDTH, 11, FIFO address width (depth 2^DEPTH_WIDTH = 2048)
- BURST_LEN, 64, words per full burst; 1 ≤ BURST_LEN ≤ 2^DEPTH_WIDTH
- ADDR_WIDTH, 28, burst word-address width
- BASE_ADDR, 0, frame start word address
- clk  in  1  single clock for block and FIFO
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream word valid (not stallable)
- in_data  in  DATA_WIDTH  upstream word
- in_ready  out  1  = fifo_wr_vld (informational)
- fifo_wr_en  out  1  = in_valid
- fifo_wr_data  out  DATA_WIDTH  = in_data
- fifo_wr_vld  in  1  FIFO can accept a write
- fifo_rd_en  out  1  FIFO pop (show-ahead)
- fifo_rd_vld  in  1  FIFO head word valid
- fifo_rd_data  in  DATA_WIDTH  FIFO head word
- frame_start  in  1  pulse: restart address at BASE_ADDR, clear overflow
- flush  in  1  pulse: drain remainder as a partial burst
- flush_done  out  1  one-cycle pulse when flush completes
- burst_req  out  1  burst request, held until burst_ack
- burst_ack  in  1  memory writer accepts request
- burst_addr  out  ADDR_WIDTH  burst start word address
- burst_len  out  DEPTH_WIDTH+1  words in burst
- out_valid  out  1  data beat valid
- out_data  out  DATA_WIDTH  data beat
- out_last  out  1  final beat of burst
- out_ready  in  1  memory writer takes beat
- level  out  DEPTH_WIDTH+1  words in FIFO (0..2048)
- overflow  out  1  sticky: word dropped

## Operation
- Write event: fifo_wr_en & fifo_wr_vld. Read event: fifo_rd_en & fifo_rd_vld.
- level: +1 on write only, −1 on read only, unchanged on both/neither; registered.
- overflow set when in_valid & !fifo_wr_vld; cleared by frame_start (clear wins over set same cycle).
- States IDLE, REQ, XFER.
- IDLE: level ≥ BURST_LEN → latch burst_len=BURST_LEN, go REQ. Else flush_pend & level>0 → latch burst_len=level, clear flush_pend, mark partial, go REQ. Else flush_pend & level==0 → clear flush_pend, pulse flush_done.
- Full burst has priority over flush; flush_pend remains set until remainder < BURST_LEN handled.
- REQ: burst_req=1, burst_addr/burst_len stable; on burst_ack → XFER, beat count=0.
- XFER: out_valid = fifo_rd_vld; out_data = fifo_rd_data; fifo_rd_en = out_ready & fifo_rd_vld; out_last = out_valid & (beat == burst_len−1). On last accepted beat: addr += burst_len (mod 2^ADDR_WIDTH), → IDLE; pulse flush_done that cycle if partial.
- Outside XFER: out_valid=0, fifo_rd_en=0.
- flush pulse in any state sets flush_pend. frame_start in IDLE sets addr=BASE_ADDR immediately; in REQ/XFER it is latched and applied on IDLE entry (after the burst address update). Overflow clears immediately in any state.

## Timing
- Reset: state IDLE, addr=BASE_ADDR, level=0, burst_len=0, burst_req=0, overflow=0, flush_pend=0, flush_done=0; combinational outputs follow (out_valid=0, out_last=0, fifo_rd_en=0).
- level updates cycle after event; IDLE decision on registered level; burst_req asserts cycle after decision (≥2 cycles after BURST_LENth write).
- burst_req/addr/len registered; burst_req deasserts cycle after burst_ack.
- Data path combinational from FIFO; one beat per cycle when fifo_rd_vld & out_ready.
- Return from XFER to IDLE takes one cycle; next REQ no earlier than 2 cycles after out_last.
- rst mid-burst aborts immediately; downstream must discard partial burst.

## Test plan
- 64 consecutive writes, out_ready=1, burst_ack 3 cycles after req → one burst addr=0 len=64, 64 beats in order, out_last on beat 63, level returns 0.
- 200 writes → bursts at addr 0, 64, 128; level ends 8; flush → burst addr 192 len 8, flush_done pulse on its last beat.
- flush with level=0 in IDLE → flush_done within 2 cycles, no burst_req.
- Hold in_valid with FIFO full (fifo_wr_vld=0) → overflow=1, level stays 2048; frame_start → overflow=0.
- Random out_ready/burst_ack gaps, simultaneous write and read every cycle → level constant, no lost/duplicated words, burst_addr stable while burst_req.
- frame_start during XFER of burst at addr 64 → current burst completes, next burst addr=0; rst mid-XFER → all outputs at reset values next cycle.
